// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage of the MIPS32 SOC.
// Holds the architectural PC, drives it to the PC decoder as virtualPC, and
// registers the combinationally read instruction word into the IF/ID register.
// Next PC is PC+4, a branch target or a jump target; jump wins over branch.
// An invalid-PC fetch moves the block into HALT, which only reset leaves.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   : on a redirect the word at the current PC is kept as the delay
//               slot, and a fault on that fetch wins over the redirect.
//   undefined : on a redirect the current fetch is squashed (bubble), and an
//               invalidPC in the same cycle is ignored.
//
// Flow control: stall is a hold request from decode. While stall=1 in RUN,
// every register holds and branch/jump/invalidPC are not looked at; the
// producer keeps any redirect asserted until the cycle where stall=0.
// dbg_state_o exposes the FSM state (0 = RUN, 1 = HALT).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  input  logic        invalidPC,
  input  logic [31:0] instrIn,
  output logic [31:0] virtualPC,
  output logic [31:0] instrOut,
  output logic [31:0] fetchPC,
  output logic [31:0] pcPlus4,
  output logic        instrValid,
  output logic        halted,
  output logic [31:0] faultPC,
  output logic        dbg_state_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] seq_pc;
  logic        fault;

  // Redirect selection: jump has priority, target forced to a word boundary.
  always_comb begin
    redirect        = jumpTaken | branchTaken;
    redirect_target = (jumpTaken ? jumpTarget : branchTarget) & ~32'h0000_0003;
    seq_pc          = pc_q + 32'd4;
`ifdef DELAY_SLOT_EN
    fault           = invalidPC;
`else
    fault           = invalidPC & ~redirect;
`endif
  end

  // Next-state and register update logic; everything holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fetch_pc_d = fetch_pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_pc_d = fault_pc_q;

    case (state_q)
      RUN: begin
        if (!stall) begin
          if (fault) begin
            fault_pc_d = pc_q;
            halted_d   = 1'b1;
            valid_d    = 1'b0;
            state_d    = HALT;
          end else if (redirect) begin
            pc_d = redirect_target;
`ifdef DELAY_SLOT_EN
            instr_d    = instrIn;
            fetch_pc_d = pc_q;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
`else
            valid_d    = 1'b0;
`endif
          end else begin
            instr_d    = instrIn;
            fetch_pc_d = pc_q;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
            pc_d       = seq_pc;
          end
        end
      end
      HALT: begin
        // Frozen until reset.
      end
      default: state_d = RUN;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      fetch_pc_q <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fetch_pc_q <= fetch_pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign virtualPC   = pc_q;
  assign instrOut    = instr_q;
  assign fetchPC     = fetch_pc_q;
  assign pcPlus4     = pc_plus4_q;
  assign instrValid  = valid_q;
  assign halted      = halted_q;
  assign faultPC     = fault_pc_q;
  assign dbg_state_o = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory and PC-decoder models, a
// scoreboard of expected IF/ID contents, and a final report.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpTaken;
  logic [31:0] jumpTarget;
  logic        invalidPC;
  logic [31:0] instrIn;
  logic [31:0] virtualPC;
  logic [31:0] instrOut;
  logic [31:0] fetchPC;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        halted;
  logic [31:0] faultPC;
  logic        dbg_state_o;

  logic        inv_force;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {fetchPC, instrOut}
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_fetch_pc;
  logic [31:0] last_instr;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jumpTaken   (jumpTaken),
    .jumpTarget  (jumpTarget),
    .invalidPC   (invalidPC),
    .instrIn     (instrIn),
    .virtualPC   (virtualPC),
    .instrOut    (instrOut),
    .fetchPC     (fetchPC),
    .pcPlus4     (pcPlus4),
    .instrValid  (instrValid),
    .halted      (halted),
    .faultPC     (faultPC),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: mem[i] = 0x1000_0000 + i, word i at RST_PC + 4*i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RST_PC;
    return 32'h1000_0000 + (off >> 2);
  endfunction

  // PC decoder model: 0x00401000..0x00401FFF is outside the text segment.
  assign instrIn   = mem_word(virtualPC);
  assign invalidPC = inv_force |
                     ((virtualPC >= 32'h0040_1000) && (virtualPC < 32'h0040_2000));

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall        = 1'b0;
    branchTaken  = 1'b0;
    jumpTaken    = 1'b0;
    branchTarget = 32'd0;
    jumpTarget   = 32'd0;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    logic [31:0] p4;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e  = exp_q.pop_front();
      p4 = e[63:32] + 32'd4;
      chk32({tag, ".fetchPC"}, fetchPC, e[63:32]);
      chk32({tag, ".instrOut"}, instrOut, e[31:0]);
      chk32({tag, ".pcPlus4"}, pcPlus4, p4);
      chk1({tag, ".instrValid"}, instrValid, 1'b1);
      last_fetch_pc = e[63:32];
      last_instr    = e[31:0];
    end
  endtask

  // Driver: one unstalled sequential fetch at exp_pc.
  task automatic fetch_seq(input string tag);
    idle_inputs();
    exp_q.push_back({exp_pc, mem_word(exp_pc)});
    tick();
    pop_check(tag);
    exp_pc = exp_pc + 32'd4;
    chk32({tag, ".virtualPC"}, virtualPC, exp_pc);
  endtask

  // Driver: one unstalled redirect cycle.
  task automatic redirect(input string tag, input logic j, input logic [31:0] jt,
                          input logic b, input logic [31:0] bt);
    logic [31:0] tgt;
    stall        = 1'b0;
    jumpTaken    = j;
    jumpTarget   = jt;
    branchTaken  = b;
    branchTarget = bt;
    tgt = (j ? jt : bt) & ~32'h3;
`ifdef DELAY_SLOT_EN
    exp_q.push_back({exp_pc, mem_word(exp_pc)});
`endif
    tick();
    idle_inputs();
    chk32({tag, ".virtualPC"}, virtualPC, tgt);
`ifdef DELAY_SLOT_EN
    pop_check({tag, ".slot"});
`else
    chk1({tag, ".instrValid"}, instrValid, 1'b0);
    chk32({tag, ".fetchPC_hold"}, fetchPC, last_fetch_pc);
    chk32({tag, ".instrOut_hold"}, instrOut, last_instr);
`endif
    exp_pc = tgt;
  endtask

  initial begin
    idle_inputs();
    inv_force     = 1'b0;
    last_fetch_pc = 32'd0;
    last_instr    = 32'd0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk32("rst.virtualPC", virtualPC, RST_PC);
    chk32("rst.instrOut", instrOut, 32'd0);
    chk32("rst.fetchPC", fetchPC, 32'd0);
    chk32("rst.pcPlus4", pcPlus4, 32'd0);
    chk1("rst.instrValid", instrValid, 1'b0);
    chk1("rst.halted", halted, 1'b0);
    chk32("rst.faultPC", faultPC, 32'd0);
    chk1("rst.state", dbg_state_o, 1'b0);
    rst_n  = 1'b1;
    exp_pc = RST_PC;

    // Sequential fetch from reset
    fetch_seq("seq0");
    fetch_seq("seq1");

    // Stall for three cycles at 0x00400008 with a pending branch
    stall        = 1'b1;
    branchTaken  = 1'b1;
    branchTarget = 32'h0040_0500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("stall.virtualPC", virtualPC, 32'h0040_0008);
      chk32("stall.instrOut", instrOut, 32'h1000_0001);
      chk1("stall.instrValid", instrValid, 1'b1);
    end
    idle_inputs();

    // Branch at 0x00400008 to unaligned 0x00400102
    redirect("branch", 1'b0, 32'd0, 1'b1, 32'h0040_0102);
    chk32("branch.target", virtualPC, 32'h0040_0100);
    fetch_seq("after_branch");

    // Jump and branch while stalled: ignored
    stall        = 1'b1;
    jumpTaken    = 1'b1;
    jumpTarget   = 32'h0040_0200;
    branchTaken  = 1'b1;
    branchTarget = 32'h0040_0100;
    tick();
    tick();
    chk32("stall_redirect.virtualPC", virtualPC, 32'h0040_0104);
    // Released: jump wins over branch
    redirect("jump_prio", 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
    fetch_seq("after_jump");

`ifndef DELAY_SLOT_EN
    // invalidPC on a squashed fetch is ignored
    inv_force = 1'b1;
    redirect("squash_fault", 1'b1, 32'h0040_0300, 1'b0, 32'd0);
    inv_force = 1'b0;
    chk1("squash_fault.halted", halted, 1'b0);
`endif

    // PC wrap at top of address space
    redirect("to_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    fetch_seq("wrap");
    chk32("wrap.pc_zero", virtualPC, 32'd0);

    // Run into the invalid region
    redirect("to_edge", 1'b1, 32'h0040_0FF8, 1'b0, 32'd0);
    fetch_seq("edge0");
    fetch_seq("edge1");
    stall = 1'b1;
    tick();
    chk1("stalled_nofault.halted", halted, 1'b0);
    chk32("stalled_nofault.virtualPC", virtualPC, 32'h0040_1000);
    stall = 1'b0;
    tick();
    chk1("fault.halted", halted, 1'b1);
    chk32("fault.faultPC", faultPC, 32'h0040_1000);
    chk1("fault.instrValid", instrValid, 1'b0);
    chk32("fault.virtualPC", virtualPC, 32'h0040_1000);
    chk1("fault.state", dbg_state_o, 1'b1);

    // Halted: outputs frozen despite random stall/redirect pulses
    for (int i = 0; i < 12; i++) begin
      stall        = 1'($urandom_range(0, 1));
      branchTaken  = 1'($urandom_range(0, 1));
      jumpTaken    = 1'($urandom_range(0, 1));
      branchTarget = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
      jumpTarget   = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
      tick();
      chk32("halt.virtualPC", virtualPC, 32'h0040_1000);
      chk1("halt.halted", halted, 1'b1);
      chk32("halt.faultPC", faultPC, 32'h0040_1000);
      chk32("halt.instrOut", instrOut, 32'h1000_03FF);
      chk1("halt.instrValid", instrValid, 1'b0);
    end
    idle_inputs();

    // Reset out of HALT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("rst2.halted", halted, 1'b0);
    chk32("rst2.faultPC", faultPC, 32'd0);
    chk32("rst2.virtualPC", virtualPC, RST_PC);
    chk1("rst2.instrValid", instrValid, 1'b0);
    chk1("rst2.state", dbg_state_o, 1'b0);
    exp_pc = RST_PC;
    fetch_seq("restart0");
    fetch_seq("restart1");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
